// File: rtl/mirror_zc_tracker.sv
// mirror_zc_tracker
//   Turns the raw, asynchronous mirror position comparator output into a clean
//   zero-crossing level and measures the mirror half period, with a small
//   lock/fault supervisor on top.
//
//   Ports
//     clk_i        system clock
//     nrst_i       asynchronous active-low reset
//     enable_i     tracking enable; low returns to IDLE and clears measurement
//     mirror_fb_i  raw comparator output (asynchronous)
//     zc_o         debounced zero-crossing level, toggles per accepted edge
//     zc_pulse_o   one-cycle strobe with every zc_o toggle
//     freq_o       last legal half period in clk_i cycles
//     lock_o       high while LOCKED
//     fault_o      high while FAULT (sticky until enable_i low or reset)
module mirror_zc_tracker #(
  parameter int CNT_W_P           = 16,
  parameter int MIN_HALF_PERIOD_P = 40000,
  parameter int MAX_HALF_PERIOD_P = 55000,
  parameter int DEBOUNCE_P        = 4,
  parameter int LOCK_COUNT_P      = 4
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               enable_i,
  input  logic               mirror_fb_i,
  output logic               zc_o,
  output logic               zc_pulse_o,
  output logic [CNT_W_P-1:0] freq_o,
  output logic               lock_o,
  output logic               fault_o
);

  localparam int STAB_W = $clog2(DEBOUNCE_P + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT_P + 1);

  localparam logic [CNT_W_P-1:0] MIN_C  = CNT_W_P'(MIN_HALF_PERIOD_P);
  localparam logic [CNT_W_P-1:0] MAX_C  = CNT_W_P'(MAX_HALF_PERIOD_P);
  localparam logic [CNT_W_P-1:0] SAT_C  = CNT_W_P'(MAX_HALF_PERIOD_P + 1);
  localparam logic [CNT_W_P-1:0] CNT_1  = CNT_W_P'(1);
  localparam logic [STAB_W-1:0]  DEB_C  = STAB_W'(DEBOUNCE_P);
  localparam logic [STAB_W-1:0]  STAB_1 = STAB_W'(1);
  localparam logic [GOOD_W-1:0]  LOCK_C = GOOD_W'(LOCK_COUNT_P);
  localparam logic [GOOD_W-1:0]  GOOD_1 = GOOD_W'(1);

  // The saturation value must be representable, otherwise timeout never fires.
  if ((MAX_HALF_PERIOD_P + 1) >= (1 << CNT_W_P)) begin : g_bad_cnt_w
    $error("mirror_zc_tracker: MAX_HALF_PERIOD_P+1 does not fit in CNT_W_P bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [STAB_W-1:0]    stab_q, stab_d;
  logic [CNT_W_P-1:0]   hp_cnt_q, hp_cnt_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [CNT_W_P-1:0]   freq_q, freq_d;
  logic                 zc_q, pulse_q;

  logic active, differ, accept, timing, legal, timeout;

  // Edge acceptance only while tracking. The stability counter has to see
  // DEBOUNCE_P differing samples and then one more before the toggle, which
  // puts the zc_o change DEBOUNCE_P+2 cycles after the first sampling edge.
  assign active  = enable_i && (state_q != ST_IDLE);
  assign differ  = sync_q[1] ^ zc_q;
  assign accept  = active && differ && (stab_q == DEB_C);
  // A zero half-period counter means no edge has started timing yet.
  assign timing  = (hp_cnt_q != '0);
  assign legal   = timing && (hp_cnt_q >= MIN_C) && (hp_cnt_q <= MAX_C);
  // Fires on the cycle the counter steps onto MAX+1; an edge wins the tie.
  assign timeout = active && timing && !accept && (hp_cnt_q == MAX_C);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    stab_d   = '0;
    hp_cnt_d = '0;
    freq_d   = freq_q;

    if (active) begin
      if (differ && !accept) stab_d = stab_q + STAB_1;

      if (accept)                           hp_cnt_d = CNT_1;
      else if (timing && hp_cnt_q != SAT_C) hp_cnt_d = hp_cnt_q + CNT_1;
      else                                  hp_cnt_d = hp_cnt_q;

      if (accept && legal && (state_q != ST_FAULT)) freq_d = hp_cnt_q;
    end

    if (!enable_i) begin
      state_d = ST_IDLE;
      good_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
        ST_ACQUIRE: begin
          if (accept && timing) begin
            if (legal) begin
              if (good_q + GOOD_1 == LOCK_C) begin
                state_d = ST_LOCKED;
                good_d  = '0;
              end else begin
                good_d  = good_q + GOOD_1;
              end
            end else begin
              good_d = '0;
            end
          end else if (timeout) begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          if ((accept && !legal) || timeout) state_d = ST_FAULT;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      stab_q   <= '0;
      hp_cnt_q <= '0;
      good_q   <= '0;
      freq_q   <= '0;
      zc_q     <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], mirror_fb_i};
      stab_q   <= stab_d;
      hp_cnt_q <= hp_cnt_d;
      good_q   <= good_d;
      freq_q   <= freq_d;
      zc_q     <= zc_q ^ accept;
      pulse_q  <= accept;
    end
  end

  assign zc_o       = zc_q;
  assign zc_pulse_o = pulse_q;
  assign freq_o     = freq_q;
  assign lock_o     = (state_q == ST_LOCKED);
  assign fault_o    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_mirror_zc_tracker.sv
// Directed bench for mirror_zc_tracker with scaled-down half periods
// (MIN 40, MAX 55, nominal 46) so every scenario fits in a short run.
module tb_mirror_zc_tracker;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          enable = 1'b0;
  logic          mirror_fb = 1'b0;
  logic          zc_o, zc_pulse_o, lock_o, fault_o;
  logic [CW-1:0] freq_o;

  int   n_chk = 0;
  int   n_err = 0;
  int   edge_no = 0;
  int   pc;
  logic exp_zc = 1'b0;

  always #5 clk = ~clk;

  mirror_zc_tracker #(
    .CNT_W_P(CW), .MIN_HALF_PERIOD_P(40), .MAX_HALF_PERIOD_P(55),
    .DEBOUNCE_P(4), .LOCK_COUNT_P(4)
  ) dut (
    .clk_i(clk), .nrst_i(nrst), .enable_i(enable), .mirror_fb_i(mirror_fb),
    .zc_o(zc_o), .zc_pulse_o(zc_pulse_o), .freq_o(freq_o),
    .lock_o(lock_o), .fault_o(fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s (edge %0d): observed %0d expected %0d", tag, edge_no, obs, exp_v);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // One raw edge followed by n cycles of steady input; checks the toggle
  // lands exactly 7 edges after the drive and the outputs at that moment.
  task automatic hp(input int n, input int e_freq, input int e_lock, input int e_fault);
    mirror_fb = ~mirror_fb;
    step(6);
    chk("zc_before", 32'(zc_o), 32'(exp_zc));
    chk("pulse_before", 32'(zc_pulse_o), 32'd0);
    step(1);
    exp_zc = ~exp_zc;
    edge_no++;
    chk("zc_toggle", 32'(zc_o), 32'(exp_zc));
    chk("pulse_on", 32'(zc_pulse_o), 32'd1);
    chk("freq", 32'(freq_o), 32'(e_freq));
    chk("lock", 32'(lock_o), 32'(e_lock));
    chk("fault", 32'(fault_o), 32'(e_fault));
    step(1);
    chk("pulse_off", 32'(zc_pulse_o), 32'd0);
    step(n - 8);
  endtask

  initial begin
    // reset state
    #3 nrst = 1'b0;
    #1;
    chk("rst_zc", 32'(zc_o), 32'd0);
    chk("rst_pulse", 32'(zc_pulse_o), 32'd0);
    chk("rst_freq", 32'(freq_o), 32'd0);
    chk("rst_lock", 32'(lock_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    step(2);
    nrst = 1'b1;
    enable = 1'b1;
    step(3);
    chk("acq_lock", 32'(lock_o), 32'd0);

    // acquire: first edge only starts timing, lock on the 5th edge
    hp(46, 0, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 1, 0);

    // 2-cycle glitch while locked is rejected
    hp(16, 46, 1, 0);
    mirror_fb = ~mirror_fb;
    step(2);
    mirror_fb = ~mirror_fb;
    pc = 0;
    for (int i = 0; i < 28; i++) begin
      step(1);
      pc += int'(zc_pulse_o);
    end
    chk("glitch_pulses", 32'(pc), 32'd0);
    chk("glitch_zc", 32'(zc_o), 32'(exp_zc));
    chk("glitch_lock", 32'(lock_o), 32'd1);

    // short half period (30) faults at that edge; freq frozen in FAULT
    hp(30, 46, 1, 0);
    hp(50, 46, 0, 1);
    hp(10, 46, 0, 1);
    enable = 1'b0;
    step(1);
    chk("dis_lock", 32'(lock_o), 32'd0);
    chk("dis_fault", 32'(fault_o), 32'd0);
    chk("dis_zc_hold", 32'(zc_o), 32'(exp_zc));
    chk("dis_freq_hold", 32'(freq_o), 32'd46);
    enable = 1'b1;
    step(2);

    // re-lock at 50 cycles per half period
    hp(50, 46, 0, 0);
    hp(50, 50, 0, 0);
    hp(50, 50, 0, 0);
    hp(50, 50, 0, 0);
    hp(8, 50, 1, 0);

    // input stops: fault exactly when the counter steps onto 56
    step(53);
    chk("pre_to_lock", 32'(lock_o), 32'd1);
    chk("pre_to_fault", 32'(fault_o), 32'd0);
    step(1);
    chk("to_lock", 32'(lock_o), 32'd0);
    chk("to_fault", 32'(fault_o), 32'd1);
    chk("to_freq", 32'(freq_o), 32'd50);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(2);

    // acquire 46,46,60 then steady 46: the long one resets the good count
    hp(46, 50, 0, 0);
    hp(46, 46, 0, 0);
    hp(60, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 1, 0);
    hp(20, 46, 1, 0);

    // asynchronous reset mid half period while locked
    nrst = 1'b0;
    #1;
    chk("arst_zc", 32'(zc_o), 32'd0);
    chk("arst_freq", 32'(freq_o), 32'd0);
    chk("arst_lock", 32'(lock_o), 32'd0);
    chk("arst_fault", 32'(fault_o), 32'd0);
    exp_zc = 1'b0;
    mirror_fb = 1'b0;
    step(2);
    nrst = 1'b1;
    step(3);
    hp(46, 0, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 0, 0);
    hp(46, 46, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mirror_zc_tracker.md
MIRROR_ZC_TRACKER -- requirements
Module: mirror_zc_tracker

Interface
REQ-001 SHALL have parameter CNT_W_P, default 16, width of half-period counter and freq_o.
REQ-002 SHALL have parameter MIN_HALF_PERIOD_P, default 40000, shortest legal half period in clk_i cycles.
REQ-003 SHALL have parameter MAX_HALF_PERIOD_P, default 55000, longest legal half period and timeout limit.
REQ-004 SHALL have parameter DEBOUNCE_P, default 4, consecutive stable synchronized samples required to accept an edge.
REQ-005 SHALL have parameter LOCK_COUNT_P, default 4, consecutive legal half periods required for lock.
REQ-006 SHALL have port clk_i, input, 1, system clock (500 MHz nominal).
REQ-007 SHALL have port nrst_i, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable_i, input, 1, tracking enable; low forces IDLE.
REQ-009 SHALL have port mirror_fb_i, input, 1, raw asynchronous mirror position comparator output.
REQ-010 SHALL have port zc_o, output, 1, debounced zero-crossing level, toggles once per accepted edge; feeds laserSynchronizer zc_i.
REQ-011 SHALL have port zc_pulse_o, output, 1, one-cycle strobe coincident with every zc_o toggle.
REQ-012 SHALL have port freq_o, output, CNT_W_P, last legal measured half period in clk_i cycles; feeds laserSynchronizer freq_i.
REQ-013 SHALL have port lock_o, output, 1, high in LOCKED state only.
REQ-014 SHALL have port fault_o, output, 1, sticky error, high in FAULT state only.

Function
REQ-015 SHALL pass mirror_fb_i through a 2-flop synchronizer before any other logic.
REQ-016 SHALL accept an edge when the synchronized value differs from the debounced value for DEBOUNCE_P consecutive cycles; any agreeing sample resets the stability count to 0.
REQ-017 SHALL toggle zc_o and assert zc_pulse_o exactly DEBOUNCE_P+2 cycles after the first rising clk_i edge sampling a stable changed mirror_fb_i, in every state except IDLE.
REQ-018 SHALL count half period in a CNT_W_P counter cleared to 1 on each accepted edge and incremented each cycle, saturating at MAX_HALF_PERIOD_P+1 (no wrap).
REQ-019 SHALL classify a half period as legal when MIN_HALF_PERIOD_P <= count <= MAX_HALF_PERIOD_P at the accepted edge; on legal, freq_o updates to count the same cycle zc_pulse_o asserts; on illegal, freq_o holds.
REQ-020 SHALL implement states IDLE, ACQUIRE, LOCKED, FAULT.
REQ-021 IDLE: counters cleared, no edge accepted; enable_i high -> ACQUIRE; first accepted edge in ACQUIRE only starts timing (no classification).
REQ-022 ACQUIRE: legal half period increments good count; illegal half period or counter reaching MAX_HALF_PERIOD_P+1 clears good count and stays ACQUIRE; good count reaching LOCK_COUNT_P -> LOCKED.
REQ-023 LOCKED: illegal half period or counter reaching MAX_HALF_PERIOD_P+1 -> FAULT.
REQ-024 FAULT: remains until enable_i low (-> IDLE) or reset; zc_o continues tracking edges, freq_o frozen.
REQ-025 enable_i low in any state SHALL -> IDLE next cycle, clear good count, stability count and half-period counter; zc_o and freq_o hold value.
REQ-026 Edge acceptance and timeout in the same cycle SHALL treat the edge as taking priority (classified normally, no timeout).
REQ-027 Design SHALL synthesize for MAX_HALF_PERIOD_P+1 < 2^CNT_W_P; violation is a parameter error.

Reset
REQ-028 nrst_i low SHALL asynchronously force: state IDLE, zc_o 0, zc_pulse_o 0, freq_o 0, lock_o 0, fault_o 0, all counters and synchronizer flops 0.
REQ-029 Reset deassertion mid-half-period SHALL restart acquisition from IDLE; no partial measurement retained.

Verification
REQ-030 Square wave toggling every 46297 cycles, enable_i=1 -> zc_o toggles DEBOUNCE_P+2=6 cycles after each raw edge, freq_o=46297 after 2nd edge, lock_o high at 5th accepted edge (4 legal half periods).
REQ-031 Locked, inject 2-cycle glitch on mirror_fb_i -> no zc_o toggle, no zc_pulse_o, lock_o stays 1.
REQ-032 Locked, stop mirror_fb_i toggling -> fault_o and lock_o change (1, 0) exactly when counter reaches 55001; freq_o holds 46297.
REQ-033 Locked, one half period of 30000 cycles -> FAULT at that edge, zc_o still toggles, freq_o holds; enable_i low then high -> re-lock after 4 further legal half periods.
REQ-034 ACQUIRE with half periods 46297, 46297, 60000, then steady 46297 -> good count cleared at 60000 timeout, lock only after 4 consecutive legal half periods following it.
REQ-035 Assert nrst_i low mid-half-period while LOCKED -> all outputs 0 immediately (asynchronous), re-acquisition from IDLE after release.
